// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared constants and FSM encoding for the seven-band EQ mixer
package eq_pkg;
  localparam int NUM_BANDS  = 7;
  localparam int W          = 18;
  localparam int GAIN_W     = 8;
  localparam int GAIN_SHIFT = 7;
  localparam int GAIN_UNITY = 128;
  localparam int PROD_W     = W + GAIN_W + 1;
  localparam int ACC_W      = 30;
  localparam int AUDIO_MAX  = 131071;
  localparam int AUDIO_MIN  = -131072;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;
endpackage

// File: rtl/band_mac.sv
// rtl/band_mac.sv - registered signed multiply-accumulate shared across all bands
module band_mac
  import eq_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic signed [W-1:0]      i_sample,
  input  logic [GAIN_W-1:0]        i_gain,
  output logic signed [ACC_W-1:0]  o_acc
);
  logic signed [GAIN_W:0]     w_gain_s;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  // Gain is unsigned; a zero MSB keeps the signed multiply from treating 255 as -1.
  assign w_gain_s = {1'b0, i_gain};
  assign w_prod   = i_sample * w_gain_s;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - scales seven band samples by user gains and sums them into one saturated sample
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ready,
  input  logic signed [W-1:0]  band1,
  input  logic signed [W-1:0]  band2,
  input  logic signed [W-1:0]  band3,
  input  logic signed [W-1:0]  band4,
  input  logic signed [W-1:0]  band5,
  input  logic signed [W-1:0]  band6,
  input  logic signed [W-1:0]  band7,
  input  logic [GAIN_W-1:0]    gain1,
  input  logic [GAIN_W-1:0]    gain2,
  input  logic [GAIN_W-1:0]    gain3,
  input  logic [GAIN_W-1:0]    gain4,
  input  logic [GAIN_W-1:0]    gain5,
  input  logic [GAIN_W-1:0]    gain6,
  input  logic [GAIN_W-1:0]    gain7,
  input  logic                 mute,
  output logic signed [W-1:0]  audio_out,
  output logic                 out_valid,
  output logic                 overrun
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(AUDIO_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(AUDIO_MIN);
  localparam logic signed [W-1:0]     OUT_MAX = W'(AUDIO_MAX);
  localparam logic signed [W-1:0]     OUT_MIN = W'(AUDIO_MIN);
  localparam logic [2:0]              LAST_IDX = 3'(NUM_BANDS - 1);

  logic signed [W-1:0]      w_band_in [NUM_BANDS];
  logic [GAIN_W-1:0]        w_gain_in [NUM_BANDS];
  logic signed [W-1:0]      r_band    [NUM_BANDS];
  logic [GAIN_W-1:0]        r_gain    [NUM_BANDS];
  logic                     r_mute;
  logic [2:0]               r_idx;
  state_t                   r_state;
  state_t                   w_next;
  logic                     w_snap;
  logic                     w_mac_en;
  logic                     w_out_load;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [W-1:0]      w_result;

  assign w_band_in[0] = band1;
  assign w_band_in[1] = band2;
  assign w_band_in[2] = band3;
  assign w_band_in[3] = band4;
  assign w_band_in[4] = band5;
  assign w_band_in[5] = band6;
  assign w_band_in[6] = band7;
  assign w_gain_in[0] = gain1;
  assign w_gain_in[1] = gain2;
  assign w_gain_in[2] = gain3;
  assign w_gain_in[3] = gain4;
  assign w_gain_in[4] = gain5;
  assign w_gain_in[5] = gain6;
  assign w_gain_in[6] = gain7;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_snap     = 1'b0;
    w_mac_en   = 1'b0;
    w_out_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ready) begin
          w_snap = 1'b1;
          w_next = ST_MAC;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (r_idx == LAST_IDX) w_next = ST_SAT;
      end
      ST_SAT: begin
        w_out_load = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_band[i] <= '0;
        r_gain[i] <= '0;
      end
      r_mute <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_snap) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          r_band[i] <= w_band_in[i];
          r_gain[i] <= w_gain_in[i];
        end
        r_mute <= mute;
        r_idx  <= '0;
      end else if (w_mac_en) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  band_mac u_band_mac (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_snap),
    .i_en     (w_mac_en),
    .i_sample (r_band[r_idx]),
    .i_gain   (r_gain[r_idx]),
    .o_acc    (w_acc)
  );

  // Arithmetic shift floors toward -inf; clamp before narrowing to the output width.
  assign w_shift = w_acc >>> GAIN_SHIFT;

  always_comb begin
    w_result = w_shift[W-1:0];
    if (r_mute) begin
      w_result = '0;
    end else if (w_shift > ACC_MAX) begin
      w_result = OUT_MAX;
    end else if (w_shift < ACC_MIN) begin
      w_result = OUT_MIN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      audio_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= w_out_load;
      if (w_out_load) audio_out <= w_result;
      if (ready && (r_state != ST_IDLE)) overrun <= 1'b1;
    end
  end
endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Synthesis-side counterpart to the seven-band analysis filter bank: takes the seven per-band audio samples, scales each by an 8-bit user gain and recombines them into one 18-bit signed audio sample. It sits between the band filters and the AC97 output path, runs once per audio `ready` strobe (48 kHz), and uses one shared multiplier, stepped over the bands by a small FSM.

## Interface
- `NUM_BANDS`, 7, number of bands summed.
- `W`, 18, audio sample width (signed).
- `GAIN_SHIFT`, 7, gain fraction bits; gain 128 = unity.
- `clock` in 1: system clock (27 MHz). One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `ready` in 1: one-cycle new-sample strobe.
- `band1`..`band7` in 18 each: signed band samples.
- `gain1`..`gain7` in 8 each: unsigned band gains, Q1.7.
- `mute` in 1: force output to zero.
- `audio_out` out 18: signed mixed sample.
- `out_valid` out 1: one-cycle pulse when `audio_out` updates.
- `overrun` out 1: sticky; set if `ready` arrives while busy.

## Operation
- States: IDLE, MAC, SAT.
- IDLE: on `ready`, latch all bands, gains and `mute` into a snapshot. Clear accumulator and band index. Go to MAC.
- MAC: each cycle, add one product to the accumulator: `acc += band[idx] * $signed({1'b0, gain[idx]})`.
  - Product is 18 × 9 signed = 27 bits.
  - Accumulator is 30 bits signed; this cannot overflow for 7 bands.
  - `idx` runs 0..6. After idx 6, go to SAT.
- SAT: form `acc >>> GAIN_SHIFT` (arithmetic shift, truncation toward −∞).
  - Clamp to the range [−131072, +131071].
  - If the snapshot `mute` = 1, the result is 0.
  - Register the result into `audio_out`, pulse `out_valid`, return to IDLE.
- `ready` in MAC or SAT is ignored and sets `overrun`. The sample in flight completes unchanged.
- `ready` in the same cycle as the SAT→IDLE transition counts as busy and sets `overrun`.
- `overrun` clears only on reset.
- Inputs may change after the `ready` cycle; only the snapshot is used.

## Timing
- Reset values: `audio_out` = 0, `out_valid` = 0, `overrun` = 0, state IDLE, accumulator 0.
- Edge E0 samples `ready` and takes the snapshot. Edges E1..E7 accumulate bands 1..7. Edge E8 (SAT) writes `audio_out` and sets `out_valid` = 1. Edge E9 clears `out_valid`.
- Latency is 8 clocks from the `ready` edge to valid output.
- Busy window is E0..E8. The earliest accepted next `ready` is sampled at E9.
- At 27 MHz and 48 kHz there are 562 clocks per sample, so overrun indicates an upstream fault.
- `audio_out` holds its value between updates.
- Reset asserted mid-MAC or mid-SAT:
  - The next edge returns to IDLE and zeroes all outputs.
  - No `out_valid` is produced for the aborted sample.
  - `ready` coincident with `reset` is ignored.

## Structure
- Shared package `eq_pkg` holds:
  - `NUM_BANDS`, `W`, `GAIN_SHIFT`, `GAIN_UNITY` = 128.
  - The saturation limits `AUDIO_MAX` = 131071 and `AUDIO_MIN` = −131072.
  - The FSM state encoding (IDLE = 0, MAC = 1, SAT = 2).
- One sub-module, `band_mac`: a registered multiply-accumulate with `clear` and `en` inputs. The top level owns the FSM, snapshot registers, band/gain mux and saturation.

## Test plan
- Unity: all gains 128, bands 1000, 2000, −500, 0, 0, 0, 0, `ready` pulse → `audio_out` = 2500, `out_valid` exactly 8 clocks after `ready`, 1 cycle wide.
- Gains and truncation: band1 = −3 with gain1 = 64, all other gains 0 → `audio_out` = −2 (−192 >>> 7). Band1 = 1000 with gain1 = 255 → 1992.
- Saturation: all bands 131071, gains 255 → `audio_out` = 131071. All bands −131072, gains 255 → −131072.
- Mute and snapshot: `mute` = 1 during `ready` with nonzero bands → `audio_out` = 0. Separately, change bands one cycle after `ready` → output still reflects the latched values.
- Overrun: second `ready` 3 clocks after the first → first result correct, only one `out_valid`, `overrun` = 1 and staying 1. A `ready` at E9 is accepted normally.
- Reset: assert `reset` at E4 of an operation → no `out_valid`, `audio_out` = 0, `overrun` = 0. A following `ready` produces a correct result after 8 clocks.
